busmatrix_arb_param: RTL and testbench
======================================

# busmatrix_arb_param

Parametrised output-stage arbiter for the AHB bus matrix: one instance per slave port selects which of `NUM_PORTS` input stages drives the shared slave. It generalises the fixed-priority per-slave arbiters with four additions:
- a configurable port count;
- a selectable fixed-priority or round-robin policy;
- fixed-length burst protection, so a burst is never re-arbitrated mid-way;
- a one-hot grant output.

It sits between the input stages' request lines and the output-stage multiplexer select.

## Interface
Parameters:
- `NUM_PORTS`, 5: number of input ports, 2..16.
- `PORT_W`, `$clog2(NUM_PORTS)`: width of the port address. Localparam, not overridable.
- `ARB_MODE`, 0: 0 = fixed priority (port 0 highest), 1 = round-robin.
- `BURST_HOLD`, 1: 1 = hold the grant for the full length of an INCR4/8/16 or WRAP4/8/16 burst; 0 = disable the hold.

Ports:
- `HCLK`  in  1  AHB clock. This is the only clock.
- `HRESETn`  in  1  reset, synchronous, active-low.
- `req_port`  in  `NUM_PORTS`  per-port request; bit i belongs to input port i.
- `HREADYM`  in  1  slave transfer done. All register updates are qualified by this signal.
- `HSELM`  in  1  slave select of the currently muxed address phase.
- `HTRANSM`  in  2  transfer type of the muxed address phase.
- `HBURSTM`  in  3  burst type of the muxed address phase.
- `HMASTLOCKM`  in  1  locked transfer.
- `addr_in_port`  out  `PORT_W`  selected port index.
- `no_port`  out  1  no port selected.
- `grant_onehot`  out  `NUM_PORTS`  one-hot decode of `addr_in_port`. It is all-zero whenever `no_port` = 1.

## Operation
Definitions:
- `active` = `HSELM` & (`HTRANSM` != IDLE).
- The current port is `addr_in_port`.

Next-port selection is combinational. The rules below are listed in priority order:
1. `HMASTLOCKM` = 1: keep the current port.
2. `BURST_HOLD` = 1 and `beats_left` != 0: keep the current port.
3. Fixed mode: grant the lowest index i for which `req_port`[i] is set, or for which i is the current port and `active` = 1.
4. Round-robin mode:
   - If the current port is `active`, keep it.
   - Otherwise, grant the first requesting port searching upward from `rr_last`+1, wrapping modulo `NUM_PORTS`.
5. No candidate and `HSELM` = 1: keep the current port.
6. Otherwise, set `no_port` = 1. `addr_in_port` keeps its value.

Beat counter (`beats_left`, 4 bits, runs only when `BURST_HOLD` = 1). All updates happen only on `HREADYM` = 1:
- NONSEQ with `HSELM` = 1: load the burst length minus one. INCR4/WRAP4 load 3; INCR8/WRAP8 load 7; INCR16/WRAP16 load 15; SINGLE/INCR load 0.
- SEQ with `beats_left` != 0: decrement by 1.
- BUSY: hold the value.
- IDLE, or `HSELM` = 0: clear to 0. This covers early burst termination.

Round-robin pointer (`rr_last`):
- Loads the newly granted index whenever the grant changes to a different port, or changes from `no_port` to a port.

State view:
- NONE: `no_port` = 1.
- OWNED: a port is granted and `beats_left` = 0.
- BURST: a port is granted and `beats_left` != 0.
- NONE→OWNED/BURST on a granting update; BURST→OWNED when the counter reaches 0; OWNED→NONE per rule 6.

## Timing
- All outputs are registered and change only on the `HCLK` edge where `HREADYM` = 1. When `HREADYM` = 0, every register holds, including the counter and `rr_last`.
- Request-to-grant latency is one cycle, given `HREADYM` = 1.
- Reset values: `no_port` = 1, `addr_in_port` = 0, `grant_onehot` = 0, `beats_left` = 0, `rr_last` = `NUM_PORTS`-1, so port 0 wins first.
- Reset asserted mid-burst aborts the burst on the same edge; the outputs take their reset values.
- Simultaneous requests are resolved entirely by the policy. A new request never pre-empts rule 1 or rule 2.
- The last beat of a burst (`beats_left` = 1, SEQ, `HREADYM` = 1) both decrements the counter to 0 and re-arbitrates on that same edge.

## Structure
- Shared package `busmatrix_arb_pkg` holds:
  - the HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ);
  - the HBURST encodings;
  - the `ARB_FIXED`/`ARB_RR` constants;
  - a function `burst_beats(hburst)` that returns the beat count minus one.
- One sub-module, `busmatrix_arb_beat_cnt`, contains the beat counter and exports `beats_left != 0`.
- The priority and round-robin search is a parametrised loop inside the top module.

## Test plan
- **Reset / idle:** hold `HRESETn` low for 2 cycles, then release with all requests at 0 and `HSELM` = 0 → `no_port` = 1, `addr_in_port` = 0, `grant_onehot` = 0.
- **Fixed priority:** `ARB_MODE` = 0, `req_port` = 5'b10110, `HREADYM` = 1 → next cycle `addr_in_port` = 1 and `grant_onehot` = 5'b00010.
- **Round-robin rotation:** `ARB_MODE` = 1, ports 0, 2 and 3 request continuously, and each granted port issues a single NONSEQ and then goes IDLE → grant sequence 0, 2, 3, 0.
- **Burst hold:** port 3 starts an INCR4 NONSEQ; port 0 requests during beat 2 → port 3 is held for 4 beats; port 0 is granted on the edge of the last SEQ. With `HREADYM` low for 3 cycles mid-burst, the counter and grant are frozen.
- **Early termination and lock:**
  - Port 1 starts a WRAP8 and goes IDLE after 3 beats while port 0 requests → port 0 is granted on the next edge.
  - With `HMASTLOCKM` = 1 and higher-priority requests present → the grant is unchanged.
- **Reset mid-burst:** assert `HRESETn` = 0 during beat 5 of an INCR16 → on the same edge `no_port` = 1, `addr_in_port` = 0 and `beats_left` = 0. After release, arbitration restarts from port 0.

Source files
------------

// File: rtl/busmatrix_arb_pkg.sv
// Shared definitions for the bus-matrix output-stage arbiter:
// AHB transfer/burst encodings, arbitration policy codes and the burst
// length helper used by the beat counter.
package busmatrix_arb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;
   localparam logic [2:0] HBURST_WRAP4  = 3'b010;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;
   localparam logic [2:0] HBURST_WRAP8  = 3'b100;
   localparam logic [2:0] HBURST_INCR8  = 3'b101;
   localparam logic [2:0] HBURST_WRAP16 = 3'b110;
   localparam logic [2:0] HBURST_INCR16 = 3'b111;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   // Width of the remaining-beats counter (longest burst is 16 beats).
   localparam int BEAT_W = 4;

   // Beats still to come after the NONSEQ of a fixed-length burst.
   // Undefined-length (INCR) and SINGLE transfers need no protection.
   function automatic logic [BEAT_W-1:0] burst_beats(input logic [2:0] hburst);
      logic [BEAT_W-1:0] beats;
      case (hburst)
         HBURST_WRAP4,  HBURST_INCR4:  beats = 4'd3;
         HBURST_WRAP8,  HBURST_INCR8:  beats = 4'd7;
         HBURST_WRAP16, HBURST_INCR16: beats = 4'd15;
         default:                      beats = 4'd0;
      endcase
      return beats;
   endfunction

endpackage

// File: rtl/busmatrix_arb_beat_cnt.sv
// Remaining-beat counter for the address phase currently muxed onto the
// slave. It tells the arbiter when a fixed-length burst must not be
// re-arbitrated. The hold flag is dropped on the edge that ends the burst
// (last SEQ, IDLE or deselect) so that edge can already re-arbitrate.
module busmatrix_arb_beat_cnt
   import busmatrix_arb_pkg::*;
#(
   parameter int BURST_HOLD = 1
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       hready_i,
   input  logic       hsel_i,
   input  logic [1:0] htrans_i,
   input  logic [2:0] hburst_i,
   output logic       hold_o
);

   logic [BEAT_W-1:0] beats_q;
   logic [BEAT_W-1:0] beats_d;

   // Next counter value: load on NONSEQ, count SEQ beats, freeze on BUSY
   // or a stalled slave, clear on IDLE/deselect (early termination).
   always_comb begin
      beats_d = beats_q;
      if ((BURST_HOLD != 0) && hready_i) begin
         if (!hsel_i || (htrans_i == HTRANS_IDLE)) begin
            beats_d = '0;
         end else if (htrans_i == HTRANS_NONSEQ) begin
            beats_d = burst_beats(hburst_i);
         end else if ((htrans_i == HTRANS_SEQ) && (beats_q != '0)) begin
            beats_d = beats_q - BEAT_W'(1);
         end
      end
   end

   // Counter register; reset aborts any burst in progress.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         beats_q <= '0;
      end else begin
         beats_q <= beats_d;
      end
   end

   // Burst still running and not finishing on this edge.
   assign hold_o = (beats_q != '0) && (beats_d != '0);

endmodule

// File: rtl/busmatrix_arb_param.sv
// Output-stage arbiter for one slave port of the AHB bus matrix. Picks
// which input stage drives the slave, with fixed-priority or round-robin
// policy, locked-transfer and fixed-length burst protection, and a
// registered one-hot grant alongside the encoded port index.
module busmatrix_arb_param
   import busmatrix_arb_pkg::*;
#(
   parameter int NUM_PORTS  = 5,
   parameter int ARB_MODE   = 0,
   parameter int BURST_HOLD = 1,
   localparam int PORT_W    = $clog2(NUM_PORTS)
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic [NUM_PORTS-1:0] req_port,
   input  logic                 HREADYM,
   input  logic                 HSELM,
   input  logic [1:0]           HTRANSM,
   input  logic [2:0]           HBURSTM,
   input  logic                 HMASTLOCKM,
   output logic [PORT_W-1:0]    addr_in_port,
   output logic                 no_port,
   output logic [NUM_PORTS-1:0] grant_onehot
);

   logic [PORT_W-1:0]    addr_q;
   logic [PORT_W-1:0]    addr_d;
   logic                 no_port_q;
   logic                 no_port_d;
   logic [NUM_PORTS-1:0] grant_q;
   logic [NUM_PORTS-1:0] grant_d;
   logic [PORT_W-1:0]    rr_last_q;
   logic [PORT_W-1:0]    rr_last_d;

   logic                 burst_hold;
   logic                 cur_active;
   logic                 found;
   logic [PORT_W-1:0]    cand;

   // The muxed address phase only counts as the owner's if a port is granted.
   assign cur_active = !no_port_q && HSELM && (HTRANSM != HTRANS_IDLE);

   busmatrix_arb_beat_cnt #(
      .BURST_HOLD (BURST_HOLD)
   ) u_beat_cnt (
      .clk_i    (HCLK),
      .rst_ni   (HRESETn),
      .hready_i (HREADYM),
      .hsel_i   (HSELM),
      .htrans_i (HTRANSM),
      .hburst_i (HBURSTM),
      .hold_o   (burst_hold)
   );

   // Candidate search: lowest index for fixed priority, or the first
   // requester after the last winner for round-robin.
   always_comb begin
      found = 1'b0;
      cand  = addr_q;
      if (ARB_MODE == ARB_RR) begin
         if (cur_active) begin
            found = 1'b1;
            cand  = addr_q;
         end else begin
            for (int k = 1; k <= NUM_PORTS; k++) begin
               if (!found && req_port[PORT_W'((int'(rr_last_q) + k) % NUM_PORTS)]) begin
                  found = 1'b1;
                  cand  = PORT_W'((int'(rr_last_q) + k) % NUM_PORTS);
               end
            end
         end
      end else begin
         for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_port[i] || (cur_active && (addr_q == PORT_W'(i)))) begin
               found = 1'b1;
               cand  = PORT_W'(i);
            end
         end
      end
   end

   // Grant decision in priority order: lock, burst, policy, keep while
   // selected, otherwise release the slave. Index is kept on release.
   always_comb begin
      addr_d    = addr_q;
      no_port_d = no_port_q;
      if (HMASTLOCKM) begin
         addr_d    = addr_q;
         no_port_d = no_port_q;
      end else if (burst_hold) begin
         addr_d    = addr_q;
         no_port_d = no_port_q;
      end else if (found) begin
         addr_d    = cand;
         no_port_d = 1'b0;
      end else if (HSELM) begin
         addr_d    = addr_q;
         no_port_d = no_port_q;
      end else begin
         no_port_d = 1'b1;
      end
   end

   // One-hot decode of the next grant and round-robin pointer update.
   always_comb begin
      grant_d = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         grant_d[i] = !no_port_d && (addr_d == PORT_W'(i));
      end
      rr_last_d = rr_last_q;
      if (!no_port_d && (no_port_q || (addr_d != addr_q))) begin
         rr_last_d = addr_d;
      end
   end

   // Arbiter state; only advances when the slave completes a transfer.
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         addr_q    <= '0;
         no_port_q <= 1'b1;
         grant_q   <= '0;
         rr_last_q <= PORT_W'(NUM_PORTS - 1);
      end else if (HREADYM) begin
         addr_q    <= addr_d;
         no_port_q <= no_port_d;
         grant_q   <= grant_d;
         rr_last_q <= rr_last_d;
      end
   end

   assign addr_in_port = addr_q;
   assign no_port      = no_port_q;
   assign grant_onehot = grant_q;

endmodule

// File: tb/tb_busmatrix_arb_param.sv
// Directed bench for busmatrix_arb_param: a fixed-priority and a
// round-robin instance share the same stimulus.
module tb_busmatrix_arb_param;
   import busmatrix_arb_pkg::*;

   localparam int N  = 5;
   localparam int PW = 3;

   logic          HCLK = 1'b0;
   logic          HRESETn;
   logic [N-1:0]  req;
   logic          rdy;
   logic          sel;
   logic [1:0]    trans;
   logic [2:0]    burst;
   logic          lock;

   logic [PW-1:0] fx_addr, rr_addr;
   logic          fx_nop, rr_nop;
   logic [N-1:0]  fx_oh, rr_oh;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 HCLK = ~HCLK;

   busmatrix_arb_param #(.NUM_PORTS(N), .ARB_MODE(0), .BURST_HOLD(1)) dut_fx (
      .HCLK(HCLK), .HRESETn(HRESETn), .req_port(req), .HREADYM(rdy),
      .HSELM(sel), .HTRANSM(trans), .HBURSTM(burst), .HMASTLOCKM(lock),
      .addr_in_port(fx_addr), .no_port(fx_nop), .grant_onehot(fx_oh)
   );

   busmatrix_arb_param #(.NUM_PORTS(N), .ARB_MODE(1), .BURST_HOLD(1)) dut_rr (
      .HCLK(HCLK), .HRESETn(HRESETn), .req_port(req), .HREADYM(rdy),
      .HSELM(sel), .HTRANSM(trans), .HBURSTM(burst), .HMASTLOCKM(lock),
      .addr_in_port(rr_addr), .no_port(rr_nop), .grant_onehot(rr_oh)
   );

   typedef struct {
      logic [N-1:0]  req;
      logic          sel;
      logic [1:0]    trans;
      logic [2:0]    burst;
      logic          lock;
      logic          rdy;
      logic [PW-1:0] e_addr;
      logic          e_nop;
      logic [N-1:0]  e_oh;
   } vec_t;

   vec_t tbl[24];

   function automatic vec_t mk(input logic [N-1:0] r, input logic s, input logic [1:0] t,
                               input logic [2:0] b, input logic l, input logic y,
                               input logic [PW-1:0] a, input logic np, input logic [N-1:0] oh);
      vec_t v;
      v.req = r; v.sel = s; v.trans = t; v.burst = b; v.lock = l; v.rdy = y;
      v.e_addr = a; v.e_nop = np; v.e_oh = oh;
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic drive(input logic [N-1:0] r, input logic s, input logic [1:0] t,
                        input logic [2:0] b, input logic l, input logic y);
      req = r; sel = s; trans = t; burst = b; lock = l; rdy = y;
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic chk_fx(input string name, input int a, input int np, input int oh);
      check({name, " fx addr"}, int'(fx_addr), a);
      check({name, " fx no_port"}, int'(fx_nop), np);
      check({name, " fx onehot"}, int'(fx_oh), oh);
   endtask

   task automatic chk_rr(input string name, input int a, input int np, input int oh);
      check({name, " rr addr"}, int'(rr_addr), a);
      check({name, " rr no_port"}, int'(rr_nop), np);
      check({name, " rr onehot"}, int'(rr_oh), oh);
   endtask

   initial begin
      HRESETn = 1'b0;
      drive(5'b00000, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0, 1'b1);

      // ---------------- reset / idle ----------------
      tick(); tick();
      chk_fx("reset", 0, 1, 0);
      chk_rr("reset", 0, 1, 0);
      HRESETn = 1'b1;
      tick();
      chk_fx("idle after reset", 0, 1, 0);

      // ---------------- fixed-priority table ----------------
      //           req      sel   trans          burst          lk    rdy   addr  nop   onehot
      tbl[0]  = mk(5'b10110, 1'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 1'b1, 3'd1, 1'b0, 5'b00010);
      tbl[1]  = mk(5'b10110, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 1'b1, 3'd1, 1'b0, 5'b00010);
      tbl[2]  = mk(5'b10100, 1'b1, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 1'b1, 3'd2, 1'b0, 5'b00100);
      tbl[3]  = mk(5'b00000, 1'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 1'b1, 3'd2, 1'b1, 5'b00000);
      tbl[4]  = mk(5'b01000, 1'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 1'b1, 3'd3, 1'b0, 5'b01000);
      // port 3 INCR4, port 0 requests from beat 2, slave stalls 3 cycles
      tbl[5]  = mk(5'b01000, 1'b1, HTRANS_NONSEQ, HBURST_INCR4,  1'b0, 1'b1, 3'd3, 1'b0, 5'b01000);
      tbl[6]  = mk(5'b01001, 1'b1, HTRANS_SEQ,    HBURST_INCR4,  1'b0, 1'b1, 3'd3, 1'b0, 5'b01000);
      tbl[7]  = mk(5'b01001, 1'b1, HTRANS_SEQ,    HBURST_INCR4,  1'b0, 1'b0, 3'd3, 1'b0, 5'b01000);
      tbl[8]  = mk(5'b01001, 1'b1, HTRANS_SEQ,    HBURST_INCR4,  1'b0, 1'b0, 3'd3, 1'b0, 5'b01000);
      tbl[9]  = mk(5'b01001, 1'b1, HTRANS_SEQ,    HBURST_INCR4,  1'b0, 1'b0, 3'd3, 1'b0, 5'b01000);
      tbl[10] = mk(5'b01001, 1'b1, HTRANS_SEQ,    HBURST_INCR4,  1'b0, 1'b1, 3'd3, 1'b0, 5'b01000);
      tbl[11] = mk(5'b01001, 1'b1, HTRANS_SEQ,    HBURST_INCR4,  1'b0, 1'b1, 3'd0, 1'b0, 5'b00001);
      // port 1 WRAP8 terminated early after 3 beats
      tbl[12] = mk(5'b00010, 1'b1, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 1'b1, 3'd1, 1'b0, 5'b00010);
      tbl[13] = mk(5'b00010, 1'b1, HTRANS_NONSEQ, HBURST_WRAP8,  1'b0, 1'b1, 3'd1, 1'b0, 5'b00010);
      tbl[14] = mk(5'b00011, 1'b1, HTRANS_SEQ,    HBURST_WRAP8,  1'b0, 1'b1, 3'd1, 1'b0, 5'b00010);
      tbl[15] = mk(5'b00011, 1'b1, HTRANS_SEQ,    HBURST_WRAP8,  1'b0, 1'b1, 3'd1, 1'b0, 5'b00010);
      tbl[16] = mk(5'b00011, 1'b1, HTRANS_IDLE,   HBURST_WRAP8,  1'b0, 1'b1, 3'd0, 1'b0, 5'b00001);
      // locked transfers on port 2 against higher-priority requests
      tbl[17] = mk(5'b00100, 1'b1, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 1'b1, 3'd2, 1'b0, 5'b00100);
      tbl[18] = mk(5'b00101, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b1, 3'd2, 1'b0, 5'b00100);
      tbl[19] = mk(5'b00111, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b1, 3'd2, 1'b0, 5'b00100);
      tbl[20] = mk(5'b00111, 1'b1, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 1'b1, 3'd0, 1'b0, 5'b00001);
      // stall freezes arbitration, keep while selected, then release
      tbl[21] = mk(5'b00010, 1'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 1'b0, 3'd0, 1'b0, 5'b00001);
      tbl[22] = mk(5'b00000, 1'b1, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 1'b1, 3'd0, 1'b0, 5'b00001);
      tbl[23] = mk(5'b00000, 1'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 1'b1, 3'd0, 1'b1, 5'b00000);

      for (int i = 0; i < 24; i++) begin
         drive(tbl[i].req, tbl[i].sel, tbl[i].trans, tbl[i].burst, tbl[i].lock, tbl[i].rdy);
         tick();
         chk_fx($sformatf("vec%0d", i), int'(tbl[i].e_addr), int'(tbl[i].e_nop), int'(tbl[i].e_oh));
      end

      // ---------------- round-robin rotation ----------------
      HRESETn = 1'b0;
      drive(5'b00000, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0, 1'b1);
      tick(); tick();
      HRESETn = 1'b1;
      drive(5'b01101, 1'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 1'b1); tick(); chk_rr("rrA", 0, 0, 5'b00001);
      drive(5'b01101, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 1'b1); tick(); chk_rr("rrB", 0, 0, 5'b00001);
      drive(5'b01101, 1'b1, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 1'b1); tick(); chk_rr("rrC", 2, 0, 5'b00100);
      drive(5'b01101, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 1'b1); tick(); chk_rr("rrD", 2, 0, 5'b00100);
      drive(5'b01101, 1'b1, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 1'b1); tick(); chk_rr("rrE", 3, 0, 5'b01000);
      drive(5'b01101, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 1'b1); tick(); chk_rr("rrF", 3, 0, 5'b01000);
      drive(5'b01101, 1'b1, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 1'b1); tick(); chk_rr("rrG", 0, 0, 5'b00001);

      // ---------------- reset in the middle of an INCR16 ----------------
      drive(5'b01101, 1'b1, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 1'b1); tick(); chk_rr("rrH", 2, 0, 5'b00100);
      drive(5'b01101, 1'b1, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 1'b1); tick(); chk_rr("rrI", 3, 0, 5'b01000);
      drive(5'b01101, 1'b1, HTRANS_NONSEQ, HBURST_INCR16, 1'b0, 1'b1); tick(); chk_rr("b16 beat1", 3, 0, 5'b01000);
      for (int b = 2; b <= 4; b++) begin
         drive(5'b01101, 1'b1, HTRANS_SEQ, HBURST_INCR16, 1'b0, 1'b1);
         tick();
         chk_rr($sformatf("b16 beat%0d", b), 3, 0, 5'b01000);
      end
      HRESETn = 1'b0;
      drive(5'b01101, 1'b1, HTRANS_SEQ, HBURST_INCR16, 1'b0, 1'b1);
      tick();
      chk_rr("reset beat5", 0, 1, 5'b00000);
      chk_fx("reset beat5", 0, 1, 5'b00000);
      // counter and pointer must both be back at reset values here
      HRESETn = 1'b1;
      drive(5'b10001, 1'b1, HTRANS_SEQ, HBURST_INCR16, 1'b0, 1'b1);
      tick();
      chk_rr("restart", 0, 0, 5'b00001);
      chk_fx("restart", 0, 0, 5'b00001);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
